// File: rtl/uart_sys_ctrl.sv
// uart_sys_ctrl: command sequencer between the UART RX byte stream and the
// register file / ALU. It parses command frames, sequences register-file
// writes and reads and ALU operations, and queues result bytes to the TX FIFO.
// State is registered; every strobe is a combinational decode of the current
// state and the inputs, so a strobe lands in the same cycle as its trigger.
module uart_sys_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    FIFO_FULL,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    CMD_ERR
);

    localparam int TW = $clog2(WAIT_TIMEOUT);

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

    // ALU operands live at fixed register-file slots 0 and 1
    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

    localparam logic [TW-1:0] TMR_LAST = TW'(WAIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        ALU_A    = 4'd5,
        ALU_B    = 4'd6,
        ALU_F    = 4'd7,
        ALU_WAIT = 4'd8,
        TX_RD    = 4'd9,
        TX_LSB   = 4'd10,
        TX_MSB   = 4'd11
    } state_t;

    state_t                  cs;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   tx_reg;
    logic [2*DATA_WIDTH-1:0] alu_reg;
    logic [TW-1:0]           tmr;

    logic tmr_done;
    assign tmr_done = (tmr == TMR_LAST);

    // Sequencer state, captured operands/results and the wait-state timer
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cs       <= IDLE;
            addr_reg <= '0;
            tx_reg   <= '0;
            alu_reg  <= '0;
            tmr      <= '0;
        end else begin
            case (cs)
                IDLE: if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:  cs <= WR_ADDR;
                        CMD_RD:  cs <= RD_ADDR;
                        CMD_ALU: cs <= ALU_A;
                        CMD_FUN: cs <= ALU_F;
                        default: cs <= IDLE;
                    endcase
                end
                WR_ADDR: if (RX_D_VLD) begin
                    addr_reg <= RX_P_DATA[ADDR_WIDTH-1:0];
                    cs       <= WR_DATA;
                end
                WR_DATA: if (RX_D_VLD) cs <= IDLE;
                RD_ADDR: if (RX_D_VLD) begin
                    tmr <= '0;
                    cs  <= RD_WAIT;
                end
                RD_WAIT: begin
                    // a valid in the timeout cycle still completes the read
                    if (RdData_Valid) begin
                        tx_reg <= RdData;
                        cs     <= TX_RD;
                    end else if (tmr_done) begin
                        cs <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ALU_A: if (RX_D_VLD) cs <= ALU_B;
                ALU_B: if (RX_D_VLD) cs <= ALU_F;
                ALU_F: if (RX_D_VLD) begin
                    tmr <= '0;
                    cs  <= ALU_WAIT;
                end
                ALU_WAIT: begin
                    if (OUT_Valid) begin
                        alu_reg <= ALU_OUT;
                        cs      <= TX_LSB;
                    end else if (tmr_done) begin
                        cs <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                TX_RD:   if (!FIFO_FULL) cs <= IDLE;
                TX_LSB:  if (!FIFO_FULL) cs <= TX_MSB;
                TX_MSB:  if (!FIFO_FULL) cs <= IDLE;
                default: cs <= IDLE;
            endcase
        end
    end

    // Output decode: strobes fire in the cycle of the byte/valid that triggers them
    always_comb begin
        WrEn      = 1'b0;
        RdEn      = 1'b0;
        Address   = '0;
        WrData    = '0;
        ALU_EN    = 1'b0;
        ALU_FUN   = 4'd0;
        CLK_EN    = 1'b0;
        TX_P_DATA = '0;
        TX_D_VLD  = 1'b0;
        CMD_ERR   = 1'b0;
        case (cs)
            IDLE: begin
                if (RX_D_VLD && RX_P_DATA != CMD_WR && RX_P_DATA != CMD_RD &&
                    RX_P_DATA != CMD_ALU && RX_P_DATA != CMD_FUN)
                    CMD_ERR = 1'b1;
            end
            WR_DATA: if (RX_D_VLD) begin
                WrEn    = 1'b1;
                Address = addr_reg;
                WrData  = RX_P_DATA;
            end
            RD_ADDR: if (RX_D_VLD) begin
                RdEn    = 1'b1;
                Address = RX_P_DATA[ADDR_WIDTH-1:0];
            end
            RD_WAIT: if (!RdData_Valid && tmr_done) CMD_ERR = 1'b1;
            ALU_A: if (RX_D_VLD) begin
                WrEn    = 1'b1;
                Address = OPA_ADDR;
                WrData  = RX_P_DATA;
            end
            ALU_B: if (RX_D_VLD) begin
                WrEn    = 1'b1;
                Address = OPB_ADDR;
                WrData  = RX_P_DATA;
            end
            ALU_F: begin
                CLK_EN = 1'b1;
                if (RX_D_VLD) begin
                    ALU_EN  = 1'b1;
                    ALU_FUN = RX_P_DATA[3:0];
                end
            end
            ALU_WAIT: begin
                CLK_EN = 1'b1;
                if (!OUT_Valid && tmr_done) CMD_ERR = 1'b1;
            end
            TX_RD: if (!FIFO_FULL) begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = tx_reg;
            end
            TX_LSB: if (!FIFO_FULL) begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = alu_reg[DATA_WIDTH-1:0];
            end
            TX_MSB: if (!FIFO_FULL) begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = alu_reg[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// tb_uart_sys_ctrl: scoreboard bench. Each command task pushes the strobe
// events it expects; a negedge monitor pops one event per observed strobe.
module tb_uart_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        OUT_Valid;
    logic        FIFO_FULL;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR;
    logic [3:0]  Address;
    logic [7:0]  WrData;
    logic [3:0]  ALU_FUN;
    logic [7:0]  TX_P_DATA;

    uart_sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    localparam int EV_WR  = 1;
    localparam int EV_RD  = 2;
    localparam int EV_ALU = 3;
    localparam int EV_TX  = 4;
    localparam int EV_ERR = 5;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mem [16];
    logic        mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int k, input logic [7:0] a, input logic [7:0] b);
        return {k[7:0], a, b, 8'h00};
    endfunction

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            default: return 16'(a ^ b);
        endcase
    endfunction

    // Monitor: every strobe cycle must match the next expected event
    always @(negedge CLK) begin : mon
        int          ns;
        logic [31:0] obs, e;
        if (mon_en) begin
            ns = int'(WrEn) + int'(RdEn) + int'(ALU_EN) + int'(TX_D_VLD) + int'(CMD_ERR);
            if (ns > 0) begin
                chk("one_strobe", ns, 1);
                obs = ev(EV_ERR, 8'h00, 8'h00);
                if (WrEn)          obs = ev(EV_WR, {4'h0, Address}, WrData);
                else if (RdEn)     obs = ev(EV_RD, {4'h0, Address}, 8'h00);
                else if (ALU_EN)   obs = ev(EV_ALU, {4'h0, ALU_FUN}, 8'h00);
                else if (TX_D_VLD) obs = ev(EV_TX, TX_P_DATA, 8'h00);
                if (TX_D_VLD) chk("tx_while_full", {31'd0, FIFO_FULL}, 0);
                if (exp_q.size() == 0) chk("sb_unexpected", obs, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_event", obs, e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic wr_cmd(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back(ev(EV_WR, {4'h0, a}, d));
        mem[a] = d;
        send_byte(8'hAA); send_byte({4'h0, a}); send_byte(d);
        idle(1);
    endtask

    // vcyc: RD_WAIT cycle (1-based) in which RdData_Valid is driven
    task automatic rd_cmd(input logic [3:0] a, input int vcyc, input bit drop_rx);
        int cyc;
        exp_q.push_back(ev(EV_RD, {4'h0, a}, 8'h00));
        exp_q.push_back(ev(EV_TX, mem[a], 8'h00));
        send_byte(8'hBB); send_byte({4'h0, a});
        cyc = 1;
        if (drop_rx) begin send_byte(8'h7F); cyc = 2; end
        while (cyc < vcyc) begin idle(1); cyc++; end
        RdData = mem[a]; RdData_Valid = 1'b1;
        idle(1);
        RdData_Valid = 1'b0; RdData = 8'h00;
        idle(2);
    endtask

    // vcyc: ALU_WAIT cycle carrying OUT_Valid; full: FIFO_FULL cycles at TX_LSB
    task automatic alu_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                           input int vcyc, input int full);
        logic [15:0] r;
        int          cyc, bad;
        r = alu_model(a, b, f);
        exp_q.push_back(ev(EV_WR, 8'h00, a));
        exp_q.push_back(ev(EV_WR, 8'h01, b));
        exp_q.push_back(ev(EV_ALU, {4'h0, f}, 8'h00));
        exp_q.push_back(ev(EV_TX, r[7:0], 8'h00));
        exp_q.push_back(ev(EV_TX, r[15:8], 8'h00));
        mem[0] = a; mem[1] = b;
        send_byte(8'hCC); send_byte(a); send_byte(b); send_byte({4'h0, f});
        @(negedge CLK);
        chk("clk_en_wait", {31'd0, CLK_EN}, 1);
        @(posedge CLK); #1;
        cyc = 2;
        while (cyc < vcyc) begin idle(1); cyc++; end
        ALU_OUT = r; OUT_Valid = 1'b1; FIFO_FULL = (full > 0);
        idle(1);
        OUT_Valid = 1'b0;
        bad = 0;
        for (int i = 0; i < full; i++) begin
            @(negedge CLK);
            bad += int'(TX_D_VLD);
            // a stray RX byte while blocked must be ignored
            RX_D_VLD = (i == 1); RX_P_DATA = (i == 1) ? 8'hAA : 8'h00;
            @(posedge CLK); #1;
        end
        RX_D_VLD = 1'b0; RX_P_DATA = 8'h00; FIFO_FULL = 1'b0;
        if (full > 0) chk("bp_hold", bad, 0);
        idle(3);
    endtask

    task automatic expect_timeout(input string tag);
        int n;
        n = 0;
        do begin @(negedge CLK); n++; end while (!CMD_ERR && n < 40);
        chk(tag, n, 15);
        @(posedge CLK); #1;
        idle(1);
    endtask

    task automatic check_quiet(input string tag);
        @(negedge CLK);
        chk(tag, {2'b0, WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR,
                  Address, WrData, ALU_FUN, TX_P_DATA}, 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RdData = 8'h00;
        RdData_Valid = 1'b0; ALU_OUT = 16'h0; OUT_Valid = 1'b0; FIFO_FULL = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_quiet("reset_outputs");
        RST = 1'b1;
        mon_en = 1'b1;
        idle(1);

        wr_cmd(4'h5, 8'h3C);                       // T1
        rd_cmd(4'h5, 1, 1'b0);                     // T2
        alu_cmd(8'h12, 8'h34, 4'd0, 2, 0);         // T3
        alu_cmd(8'h12, 8'h34, 4'd0, 2, 5);         // T4 backpressure
        alu_cmd(8'h12, 8'h34, 4'd2, 15, 0);        // valid on timeout cycle wins
        alu_cmd(8'h80, 8'h7F, 4'd2, 3, 1);
        wr_cmd(4'hA, 8'h5A);
        rd_cmd(4'hA, 4, 1'b1);                     // dropped RX in RD_WAIT
        rd_cmd(4'h5, 15, 1'b0);                    // read valid on timeout cycle

        // T5 errors
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00));
        send_byte(8'h7F);
        idle(1);
        exp_q.push_back(ev(EV_RD, 8'h02, 8'h00));
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00));
        send_byte(8'hBB); send_byte(8'h02);
        expect_timeout("rd_timeout_cycles");
        exp_q.push_back(ev(EV_ALU, 8'h03, 8'h00));
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00));
        send_byte(8'hDD); send_byte(8'h03);
        expect_timeout("alu_timeout_cycles");

        // T6 reset mid-command
        exp_q.push_back(ev(EV_WR, 8'h00, 8'h12));
        mem[0] = 8'h12;
        send_byte(8'hCC); send_byte(8'h12);
        RST = 1'b0;
        idle(1);
        RST = 1'b1;
        check_quiet("mid_reset_outputs");
        wr_cmd(4'h1, 8'hFF);
        rd_cmd(4'h1, 1, 1'b0);

        idle(4);
        chk("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
